arp_rewrite: RTL

ARP_REWRITE -- requirements
Module: arp_rewrite

---
 rtl/arp_rewrite.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arp_rewrite.sv
// arp_rewrite: ARP next-hop MAC rewrite stage between LPM and the output queues.
// Holds a 32-entry ARP table (IP -> MAC). For each packet the first beat is
// captured, the table is searched for the LPM next hop, and the header is
// rewritten (dest MAC, TTL, IP checksum, destination port) before the body
// streams through a single output register.
// Optional build macro ARP_REWRITE_TTL_CHECK_EN: when defined, hit packets with
// TTL <= 1 are not rewritten and are steered to the CPU port of the source.
module arp_rewrite #(
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned SRC_PORT_POS         = 16,
  parameter int unsigned DST_PORT_POS         = 24
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESET,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic                                S_AXIS_TLAST,

  input  logic                                arp_lookup,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       nh_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       oq_reg,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TLAST,

  input  logic                                tbl_rd_req,
  input  logic                                tbl_wr_req,
  input  logic [4:0]                          tbl_rd_addr,
  input  logic [4:0]                          tbl_wr_addr,
  input  logic [127:0]                        tbl_wr_data,
  output logic [127:0]                        tbl_rd_data,
  output logic                                tbl_rd_ack,
  output logic                                tbl_wr_ack,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]       reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       arp_miss_count
);

  localparam int unsigned TBL_DEPTH  = 32;
  localparam int unsigned TBL_AW     = 5;
  localparam int unsigned IP_W       = 32;
  localparam int unsigned MAC_W      = 48;
  localparam int unsigned ENTRY_W    = IP_W + MAC_W;
  localparam int unsigned TBL_DATA_W = 128;
  localparam int unsigned SP         = SRC_PORT_POS;
  localparam int unsigned DP         = DST_PORT_POS;

  typedef enum logic [1:0] {IDLE, SEARCH, SEND_HDR, SEND_BODY} state_t;

  state_t state;

  logic [ENTRY_W-1:0] arp_tbl [TBL_DEPTH];

  // First-beat capture
  logic [C_S_AXIS_DATA_WIDTH-1:0]   hdr_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] hdr_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  hdr_user;
  logic                             hdr_last;
  logic                             lookup_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]    nh_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]    oq_q;

  // Search and rewrite results
  logic                             hit_c;
  logic [MAC_W-1:0]                 hit_mac_c;
  logic [7:0]                       ttl_c;
  logic                             ttl_ok_c;
  logic                             fwd_c;
  logic                             miss_c;
  logic [16:0]                      cs_sum_c;
  logic [15:0]                      cs_new_c;
  logic [7:0]                       oq_dst_c;
  logic [7:0]                       cpu_dst_c;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   out_data_c;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  out_user_c;

  logic                             out_fire_c;
  logic                             in_fire_c;

  // Upper write-data bits carry no table state
  logic unused_wr_hi;
  assign unused_wr_hi = ^tbl_wr_data[TBL_DATA_W-1:ENTRY_W];

  // ARP table storage with registered read/write acknowledge; reads see pre-write contents
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) arp_tbl[TBL_AW'(i)] <= '0;
      tbl_rd_data <= '0;
      tbl_rd_ack  <= 1'b0;
      tbl_wr_ack  <= 1'b0;
    end else begin
      tbl_rd_ack <= tbl_rd_req;
      tbl_wr_ack <= tbl_wr_req;
      if (tbl_rd_req) tbl_rd_data <= {{(TBL_DATA_W-ENTRY_W){1'b0}}, arp_tbl[tbl_rd_addr]};
      if (tbl_wr_req) arp_tbl[tbl_wr_addr] <= tbl_wr_data[ENTRY_W-1:0];
    end
  end

  // Priority search: lowest index whose nonzero IP matches the next hop
  always_comb begin
    hit_c     = 1'b0;
    hit_mac_c = '0;
    for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
      if (!hit_c && (nh_q != '0) && (arp_tbl[TBL_AW'(i)][IP_W-1:0] == nh_q)) begin
        hit_c     = 1'b1;
        hit_mac_c = arp_tbl[TBL_AW'(i)][ENTRY_W-1:IP_W];
      end
    end
  end

  // CPU port of the source: odd bit next to the lowest set physical source bit
  always_comb begin
    cpu_dst_c = 8'h00;
    if (hdr_user[SP])          cpu_dst_c = 8'h02;
    else if (hdr_user[SP + 2]) cpu_dst_c = 8'h08;
    else if (hdr_user[SP + 4]) cpu_dst_c = 8'h20;
    else if (hdr_user[SP + 6]) cpu_dst_c = 8'h80;
  end

  // Header rewrite: MAC, TTL decrement, incremental checksum, destination port
  always_comb begin
    ttl_c = hdr_data[79:72];
`ifdef ARP_REWRITE_TTL_CHECK_EN
    ttl_ok_c = (ttl_c > 8'd1);
`else
    ttl_ok_c = 1'b1;
`endif
    fwd_c      = hit_c && (oq_q < C_S_AXI_DATA_WIDTH'(4)) && ttl_ok_c;
    miss_c     = lookup_q && !hit_c;
    cs_sum_c   = 17'(hdr_data[63:48]) + 17'h00100;
    cs_new_c   = cs_sum_c[15:0] + 16'(cs_sum_c[16]);
    oq_dst_c   = 8'd1 << {oq_q[1:0], 1'b0};
    out_data_c = hdr_data;
    out_user_c = hdr_user;
    if (lookup_q) begin
      if (fwd_c) begin
        out_data_c[255:208]   = hit_mac_c;
        out_data_c[79:72]     = ttl_c - 8'd1;
        out_data_c[63:48]     = cs_new_c;
        out_user_c[DP+7:DP]   = oq_dst_c;
      end else begin
        out_user_c[DP+7:DP]   = cpu_dst_c;
      end
    end
  end

  // Input ready: open in IDLE, closed in SEARCH, then follows the output register
  always_comb begin
    case (state)
      IDLE:    S_AXIS_TREADY = 1'b1;
      SEARCH:  S_AXIS_TREADY = 1'b0;
      default: S_AXIS_TREADY = !(M_AXIS_TVALID && M_AXIS_TLAST) &&
                               (!M_AXIS_TVALID || M_AXIS_TREADY);
    endcase
  end

  assign out_fire_c = M_AXIS_TVALID && M_AXIS_TREADY;
  assign in_fire_c  = S_AXIS_TVALID && S_AXIS_TREADY;

  // Packet FSM, header capture and output register
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state         <= IDLE;
      hdr_data      <= '0;
      hdr_strb      <= '0;
      hdr_user      <= '0;
      hdr_last      <= 1'b0;
      lookup_q      <= 1'b0;
      nh_q          <= '0;
      oq_q          <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TUSER  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (S_AXIS_TVALID) begin
            hdr_data <= S_AXIS_TDATA;
            hdr_strb <= S_AXIS_TSTRB;
            hdr_user <= S_AXIS_TUSER;
            hdr_last <= S_AXIS_TLAST;
            lookup_q <= arp_lookup;
            nh_q     <= nh_reg;
            oq_q     <= oq_reg;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          M_AXIS_TDATA  <= out_data_c;
          M_AXIS_TSTRB  <= hdr_strb;
          M_AXIS_TUSER  <= out_user_c;
          M_AXIS_TLAST  <= hdr_last;
          M_AXIS_TVALID <= 1'b1;
          state         <= SEND_HDR;
        end
        default: begin
          if (out_fire_c && M_AXIS_TLAST) begin
            M_AXIS_TVALID <= 1'b0;
            state         <= IDLE;
          end else begin
            if (out_fire_c) state <= SEND_BODY;
            if (in_fire_c) begin
              M_AXIS_TDATA  <= S_AXIS_TDATA;
              M_AXIS_TSTRB  <= S_AXIS_TSTRB;
              M_AXIS_TUSER  <= S_AXIS_TUSER;
              M_AXIS_TLAST  <= S_AXIS_TLAST;
              M_AXIS_TVALID <= 1'b1;
            end else if (out_fire_c) begin
              M_AXIS_TVALID <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Miss counter: software clear wins over increment, saturates at all-ones
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      arp_miss_count <= '0;
    end else if (reset == C_S_AXI_DATA_WIDTH'(1)) begin
      arp_miss_count <= '0;
    end else if ((state == SEARCH) && miss_c && (arp_miss_count != '1)) begin
      arp_miss_count <= arp_miss_count + C_S_AXI_DATA_WIDTH'(1);
    end
  end

endmodule
